add_seq: RTL and testbench

Parametrised multi-cycle adder/subtractor. It computes `WIDTH`-bit two's-complement add or subtract, `CHUNK` bits per clock, LSB chunk first, and reports carry and signed-overflow flags. It sits between operand producers and result consumers in the ALU datapath and uses valid/ready handshakes on both sides. It generalises the fixed 16-bit combinational adder with width and chunk parameters, subtract mode, flags and flow control.

---
 rtl/add_seq_if.sv | 25 ++
 rtl/add_seq.sv | 120 ++++++++++++
 tb/tb_add_seq.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/add_seq_if.sv
// rtl/add_seq_if.sv - operand/result handshake bundle for the sequential adder
interface add_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             overflow;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, sum, carry, overflow
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, sum, carry, overflow
   );
endinterface

// File: rtl/add_seq.sv
// rtl/add_seq.sv - multi-cycle chunked adder/subtractor with carry and overflow flags
module add_seq #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic      clk,
   input  logic      reset,
   add_seq_if.slave  bus
);
   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cy_q, cy_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   int               idx;
   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK-1:0] s_chunk;
   logic             c_out;
   logic             c_msb;
   logic             last;
   logic             in_ready;
   logic             out_valid;

   // Add the current chunk; the carry into the chunk MSB is recovered from a^b^s at that bit
   always_comb begin
      idx     = int'(cnt_q) * CHUNK;
      a_chunk = opa_q[idx +: CHUNK];
      b_chunk = opb_q[idx +: CHUNK];
      {c_out, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, cy_q};
      c_msb   = s_chunk[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
      last    = (cnt_q == CW'(N - 1));
   end

   // Next-state and handshake outputs; result registers move only when the last chunk finishes
   always_comb begin
      state_d   = state_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      work_d    = work_q;
      sum_d     = sum_q;
      cy_d      = cy_q;
      carry_d   = carry_q;
      ovf_d     = ovf_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               opa_d   = bus.a;
               opb_d   = bus.sub ? ~bus.b : bus.b;
               cy_d    = bus.sub;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            work_d[idx +: CHUNK] = s_chunk;
            cy_d  = c_out;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               carry_d = c_out;
               ovf_d   = c_out ^ c_msb;
               sum_d   = work_d;
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any operation in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         work_q  <= '0;
         sum_q   <= '0;
         cy_q    <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         work_q  <= work_d;
         sum_q   <= sum_d;
         cy_q    <= cy_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.sum       = sum_q;
   assign bus.carry     = carry_q;
   assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_add_seq.sv
// tb/tb_add_seq.sv - directed and random checks of add_seq in three configurations
module tb_add_seq;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        iv = 1'b0;
   logic        ordy = 1'b0;
   logic [15:0] a_s = '0;
   logic [15:0] b_s = '0;
   logic        sub_s = 1'b0;
   int          sel = 0;

   add_seq_if #(.WIDTH(16)) if_a ();
   add_seq_if #(.WIDTH(16)) if_b ();
   add_seq_if #(.WIDTH(8))  if_c ();

   assign if_a.in_valid  = iv && (sel == 0);
   assign if_b.in_valid  = iv && (sel == 1);
   assign if_c.in_valid  = iv && (sel == 2);
   assign if_a.out_ready = ordy && (sel == 0);
   assign if_b.out_ready = ordy && (sel == 1);
   assign if_c.out_ready = ordy && (sel == 2);
   assign if_a.a = a_s;       assign if_a.b = b_s;       assign if_a.sub = sub_s;
   assign if_b.a = a_s;       assign if_b.b = b_s;       assign if_b.sub = sub_s;
   assign if_c.a = a_s[7:0];  assign if_c.b = b_s[7:0];  assign if_c.sub = sub_s;

   add_seq #(.WIDTH(16), .CHUNK(4))  u_a (.clk(clk), .reset(reset), .bus(if_a));
   add_seq #(.WIDTH(16), .CHUNK(16)) u_b (.clk(clk), .reset(reset), .bus(if_b));
   add_seq #(.WIDTH(8),  .CHUNK(1))  u_c (.clk(clk), .reset(reset), .bus(if_c));

   logic        cur_ir, cur_ov, cur_c, cur_o;
   logic [15:0] cur_sum;
   always_comb begin
      cur_ir = if_a.in_ready;  cur_ov = if_a.out_valid;
      cur_sum = if_a.sum;      cur_c = if_a.carry;  cur_o = if_a.overflow;
      if (sel == 1) begin
         cur_ir = if_b.in_ready;  cur_ov = if_b.out_valid;
         cur_sum = if_b.sum;      cur_c = if_b.carry;  cur_o = if_b.overflow;
      end else if (sel == 2) begin
         cur_ir = if_c.in_ready;  cur_ov = if_c.out_valid;
         cur_sum = {8'd0, if_c.sum}; cur_c = if_c.carry; cur_o = if_c.overflow;
      end
   end

   int total = 0;
   int bad = 0;
   int lat_exp [3] = '{5, 2, 9};
   int wid [3] = '{16, 16, 8};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic void ref_model(input int w, input logic [15:0] ra, input logic [15:0] rb,
                                     input logic rs, output logic [15:0] es,
                                     output logic ec, output logic eo);
      logic [16:0] mask, aa, bb, full;
      mask = (17'd1 << w) - 17'd1;
      aa   = {1'b0, ra} & mask;
      bb   = rs ? (~{1'b0, rb}) & mask : {1'b0, rb} & mask;
      full = aa + bb + {16'd0, rs};
      es   = full[15:0] & mask[15:0];
      ec   = full[w];
      eo   = (aa[w-1] == bb[w-1]) && (es[w-1] != aa[w-1]);
   endfunction

   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                        output logic [15:0] rs, output logic rc, output logic ro, output int lat);
      @(negedge clk);
      a_s = ta; b_s = tb; sub_s = ts; iv = 1'b1;
      @(negedge clk);
      iv  = 1'b0;
      lat = 1;
      while (!cur_ov && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      rs = cur_sum; rc = cur_c; ro = cur_o;
      ordy = 1'b1;
      @(negedge clk);
      ordy = 1'b0;
      chk("in_ready_after_handshake", cur_ir, 1);
   endtask

   typedef struct {
      int          s;
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic [15:0] sum;
      logic        c;
      logic        o;
   } vec_t;

   vec_t vecs [12];

   initial begin
      logic [15:0] rs, es;
      logic        rc, ro, ec, eo;
      int          lat, k, nacc, nres;
      int          rcyc [3];
      logic [15:0] rsum [3];
      logic        saw;

      vecs[0]  = '{0, 16'h0008, 16'h0008, 1'b0, 16'h0010, 1'b0, 1'b0};
      vecs[1]  = '{0, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};
      vecs[2]  = '{0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3]  = '{0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[4]  = '{0, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[5]  = '{0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[6]  = '{0, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[7]  = '{0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[8]  = '{1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[9]  = '{2, 16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b1};
      vecs[10] = '{2, 16'h0080, 16'h0001, 1'b1, 16'h007F, 1'b1, 1'b1};
      vecs[11] = '{2, 16'h0000, 16'h0001, 1'b1, 16'h00FF, 1'b0, 1'b0};

      // reset together with in_valid: nothing may be accepted
      iv = 1'b1; a_s = 16'h1111; b_s = 16'h2222;
      repeat (2) @(negedge clk);
      chk("reset_in_ready", cur_ir, 1);
      chk("reset_out_valid", cur_ov, 0);
      chk("reset_sum", cur_sum, 0);
      chk("reset_carry", cur_c, 0);
      chk("reset_overflow", cur_o, 0);
      iv = 1'b0; reset = 1'b0;
      @(negedge clk);
      chk("no_accept_during_reset", cur_ir, 1);

      for (int i = 0; i < 12; i++) begin
         sel = vecs[i].s;
         do_op(vecs[i].a, vecs[i].b, vecs[i].sub, rs, rc, ro, lat);
         chk($sformatf("vec%0d_sum", i), rs, vecs[i].sum);
         chk($sformatf("vec%0d_carry", i), rc, vecs[i].c);
         chk($sformatf("vec%0d_ovf", i), ro, vecs[i].o);
         chk($sformatf("vec%0d_latency", i), lat, lat_exp[vecs[i].s]);
      end

      // backpressure: result holds, new operands wait for the output handshake
      sel = 0;
      @(negedge clk);
      a_s = 16'h0008; b_s = 16'h0008; sub_s = 1'b0; iv = 1'b1;
      @(negedge clk);
      iv = 1'b0;
      k = 0;
      while (!cur_ov && k < 50) begin @(negedge clk); k++; end
      chk("bp_out_valid", cur_ov, 1);
      a_s = 16'h0001; b_s = 16'h0002; iv = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_sum_hold", cur_sum, 16'h0010);
         chk("bp_in_ready_low", cur_ir, 0);
         chk("bp_valid_hold", cur_ov, 1);
         @(negedge clk);
      end
      ordy = 1'b1;
      @(negedge clk);
      ordy = 1'b0;
      chk("bp_in_ready_after", cur_ir, 1);
      chk("bp_sum_still", cur_sum, 16'h0010);
      @(negedge clk);
      iv = 1'b0;
      chk("bp_accepted", cur_ir, 0);
      k = 0;
      while (!cur_ov && k < 50) begin @(negedge clk); k++; end
      chk("bp_second_sum", cur_sum, 16'h0003);
      ordy = 1'b1;
      @(negedge clk);
      ordy = 1'b0;

      // back-to-back with in_valid and out_ready held high
      nacc = 0; nres = 0; k = 0;
      b_s = 16'h0100; sub_s = 1'b0; ordy = 1'b1;
      while (nres < 3 && k < 60) begin
         if (cur_ov) begin
            rcyc[nres] = k;
            rsum[nres] = cur_sum;
            nres++;
         end
         if (cur_ir) begin
            if (nacc < 3) begin
               a_s = 16'(nacc + 1);
               iv  = 1'b1;
               nacc++;
            end else begin
               iv = 1'b0;
            end
         end
         @(negedge clk);
         k++;
      end
      iv = 1'b0; ordy = 1'b0;
      chk("b2b_count", nres, 3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("b2b_sum%0d", i), rsum[i], 16'h0101 + 16'(i));
      end
      chk("b2b_spacing01", rcyc[1] - rcyc[0], 6);
      chk("b2b_spacing12", rcyc[2] - rcyc[1], 6);
      @(negedge clk);

      // random operands against the reference model, CHUNK=16 and WIDTH=8/CHUNK=1
      for (int s = 1; s < 3; s++) begin
         sel = s;
         for (int i = 0; i < 10; i++) begin
            logic [15:0] ra, rb;
            logic        rsub;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rsub = 1'($urandom_range(0, 1));
            if (s == 2) begin
               ra[15:8] = '0;
               rb[15:8] = '0;
            end
            ref_model(wid[s], ra, rb, rsub, es, ec, eo);
            do_op(ra, rb, rsub, rs, rc, ro, lat);
            chk($sformatf("rnd_c%0d_%0d_sum", s, i), rs, es);
            chk($sformatf("rnd_c%0d_%0d_carry", s, i), rc, ec);
            chk($sformatf("rnd_c%0d_%0d_ovf", s, i), ro, eo);
            chk($sformatf("rnd_c%0d_%0d_lat", s, i), lat, lat_exp[s]);
         end
      end

      // reset at RUN chunk 2 of 0xFFFF+0x0001
      sel = 0;
      do_op(16'h1234, 16'h0001, 1'b0, rs, rc, ro, lat);
      chk("pre_abort_sum", rs, 16'h1235);
      @(negedge clk);
      a_s = 16'hFFFF; b_s = 16'h0001; sub_s = 1'b0; iv = 1'b1;
      @(negedge clk);
      iv = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_in_ready", cur_ir, 1);
      chk("abort_out_valid", cur_ov, 0);
      chk("abort_sum", cur_sum, 16'h0000);
      saw = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (cur_ov) saw = 1'b1;
      end
      chk("abort_no_result", saw, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
